hex_keypad_scanner: RTL and testbench

//  Input-side counterpart of the hex counter/7-seg display path. Scans a 4x4

---
 rtl/hex_keypad_scanner.sv | 226 ++++++++++++++++++++++
 tb/tb_hex_keypad_scanner.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_keypad_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : hex_keypad_scanner
//  Purpose  : Scans a 4x4 active-low matrix keypad one column at a time,
//             debounces press and release, and presents the hex code of the
//             accepted key with a one-cycle strobe and a held flag.
//  Options  : KEYPAD_AUTOREPEAT_EN - re-strobe a held key after REPEAT_DELAY
//             cycles and then every REPEAT_CYCLES cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module hex_keypad_scanner #(
    parameter int SCAN_DIV        = 4096,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic       clkIn,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int                SLOT_W    = $clog2(SCAN_DIV) + 1;
    localparam int                DEB_W     = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    // Nonsensical parameter values are rejected at elaboration.
    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("hex_keypad_scanner: invalid parameter value");
    end

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        rs_meta_q, rs_q;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [DEB_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        cap_row_q, cap_row_d;
    logic [3:0]        code_q, code_d;
    logic              valid_q, valid_d;
    logic              held_q, held_d;
    logic              one_low;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int               REP_MAX   = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
    localparam int               REP_W     = $clog2(REP_MAX) + 1;
    localparam logic [REP_W-1:0] RD_LAST   = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RC_LAST   = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_first_q, rep_first_d;   // waiting for the first (longer) repeat
`endif

    // Key legend indexed by {row, column}, column 0 leftmost.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  4'hF: k = 4'hD;
            default: k = 4'h0;
        endcase
        return k;
    endfunction

    // Row number of a single-low row pattern.
    function automatic logic [1:0] row_index(input logic [3:0] p);
        logic [1:0] i;
        case (p)
            4'b1101: i = 2'd1;
            4'b1011: i = 2'd2;
            4'b0111: i = 2'd3;
            default: i = 2'd0;
        endcase
        return i;
    endfunction

    assign one_low   = (rs_q == 4'b1110) || (rs_q == 4'b1101) ||
                       (rs_q == 4'b1011) || (rs_q == 4'b0111);
    assign col       = ~(4'b0001 << col_idx_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

    // Two-flop synchronizer for the asynchronous row inputs; idle rows read high.
    always_ff @(posedge clkIn or negedge rst) begin
        if (!rst) begin
            rs_meta_q <= 4'hF;
            rs_q      <= 4'hF;
        end else begin
            rs_meta_q <= row;
            rs_q      <= rs_meta_q;
        end
    end

    // Scanner state, counters and output registers.
    always_ff @(posedge clkIn or negedge rst) begin
        if (!rst) begin
            state_q   <= S_SCAN;
            col_idx_q <= 2'd0;
            slot_q    <= '0;
            cnt_q     <= '0;
            cap_row_q <= 4'hF;
            code_q    <= 4'h0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
            cap_row_q <= cap_row_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // Auto-repeat interval counter.
    always_ff @(posedge clkIn or negedge rst) begin
        if (!rst) begin
            rep_q       <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    // Next-state logic: scan, debounce press, hold, debounce release.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        slot_d    = slot_q;
        cnt_d     = cnt_q;
        cap_row_d = cap_row_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        held_d    = held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
`endif
        case (state_q)
            S_SCAN: begin
                if (slot_q >= SLOT_LAST) begin
                    slot_d = '0;
                    if (one_low) begin
                        cap_row_d = rs_q;
                        cnt_d     = '0;
                        state_d   = S_DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            S_DEBOUNCE: begin
                if (rs_q != cap_row_q) begin
                    // Bounce: resume scanning this same column with a fresh slot.
                    state_d = S_SCAN;
                    slot_d  = '0;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d = S_PRESSED;
                    code_d  = key_map(row_index(cap_row_q), col_idx_q);
                    valid_d = 1'b1;
                    held_d  = 1'b1;
                    cnt_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_d       = '0;
                    rep_first_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PRESSED: begin
                if (rs_q == 4'hF) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_d       = '0;
                    rep_first_d = 1'b1;
                end else if (rep_q >= (rep_first_q ? RD_LAST : RC_LAST)) begin
                    valid_d     = 1'b1;
                    rep_d       = '0;
                    rep_first_d = 1'b0;
                end else begin
                    rep_d = rep_q + 1'b1;
`endif
                end
            end
            S_RELEASE: begin
                if (rs_q != 4'hF) begin
                    cnt_d = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d   = S_SCAN;
                    held_d    = 1'b0;
                    col_idx_d = col_idx_q + 2'd1;
                    slot_d    = '0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_SCAN;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_keypad_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_hex_keypad_scanner
//  Purpose  : Self-checking bench for hex_keypad_scanner with a behavioural
//             keypad matrix; table vectors, corner sequences, random presses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hex_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 8;
    localparam int RD = 16;
    localparam int RC = 8;

    logic       clkIn = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0] keys [4];          // keys[r][c] = 1 while that key is down
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         strobe_t[$];
    logic [3:0] strobe_c[$];
    logic       prev_valid = 1'b0;

    typedef struct {
        int         r;
        int         c;
        int         hold;
        logic [3:0] code;
    } vec_t;

    vec_t vecs[6];

    always #5 clkIn = ~clkIn;

    hex_keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_CYCLES  (RC)
    ) dut (
        .clkIn    (clkIn),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Keypad matrix: a row reads low when a pressed key sits on a driven-low column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r][c] && (col[c] == 1'b0)) row[r] = 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe monitor: records each strobe and checks column drive every cycle.
    always @(posedge clkIn) begin
        #1;
        cyc++;
        if (rst) begin
            checks++;
            if (!(col inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) begin
                errors++;
                $display("FAIL col_one_low: got %b", col);
            end
            if (key_valid) begin
                checks++;
                if (prev_valid) begin
                    errors++;
                    $display("FAIL valid_back_to_back: got two strobes at cycle %0d", cyc);
                end
                strobe_t.push_back(cyc);
                strobe_c.push_back(key_code);
            end
        end
        prev_valid = key_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clkIn);
    endtask

    task automatic wait_accept(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clkIn);
            if (strobe_c.size() > 0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Reference: strobes for a key held h cycles past its accept strobe.
    function automatic int exp_strobes(input int h);
        int n = 1;
        int o = RD;
        while (o <= h) begin
`ifdef KEYPAD_AUTOREPEAT_EN
            n++;
`endif
            o += RC;
        end
        return n;
    endfunction

    // Reference key legend, read straight off the keypad face.
    function automatic logic [3:0] ref_code(input int r, input int c);
        string      legend = "123A456B789C0FED";
        byte        ch;
        ch = legend[r * 4 + c];
        if (ch >= "0" && ch <= "9") return 4'(ch - "0");
        return 4'(ch - "A" + 10);
    endfunction

    task automatic press_and_release(input int r, input int c, input int h,
                                     input logic [3:0] exp_code, input string tag);
        bit ok;
        int n_exp;
        strobe_t.delete();
        strobe_c.delete();
        keys[r][c] = 1'b1;
        wait_accept(200, ok);
        chk({tag, "_accept"}, int'(ok), 1);
        if (!ok) begin
            keys[r][c] = 1'b0;
            tick(40);
            return;
        end
        chk({tag, "_held_at_accept"}, int'(key_held), 1);
        chk({tag, "_code_at_accept"}, int'(key_code), int'(exp_code));
        tick(h);
        keys[r][c] = 1'b0;
        tick(5);
        chk({tag, "_held_after_release"}, int'(key_held), 1);
        tick(25);
        chk({tag, "_held_cleared"}, int'(key_held), 0);
        n_exp = exp_strobes(h);
        chk({tag, "_strobe_count"}, strobe_c.size(), n_exp);
        for (int j = 0; j < strobe_c.size(); j++) begin
            chk({tag, "_strobe_code"}, int'(strobe_c[j]), int'(exp_code));
            if (j > 0)
                chk({tag, "_repeat_spacing"}, strobe_t[j] - strobe_t[0], RD + (j - 1) * RC);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_col;
        logic [3:0] seen;
        bit         ok;
        int         rr, cc;

        for (int r = 0; r < 4; r++) keys[r] = 4'h0;
        vecs[0] = '{r: 1, c: 2, hold: 43, code: 4'h6};
        vecs[1] = '{r: 3, c: 0, hold: 50, code: 4'h0};
        vecs[2] = '{r: 0, c: 0, hold: 27, code: 4'h1};
        vecs[3] = '{r: 2, c: 3, hold: 3,  code: 4'hC};
        vecs[4] = '{r: 0, c: 3, hold: 11, code: 4'hA};
        vecs[5] = '{r: 3, c: 2, hold: 3,  code: 4'hE};

        // Reset asserted mid-cycle takes effect immediately.
        #2 rst = 1'b0;
        #1;
        chk("reset_col", int'(col), 4'hE);
        chk("reset_code", int'(key_code), 0);
        chk("reset_valid", int'(key_valid), 0);
        chk("reset_held", int'(key_held), 0);
        tick(3);
        rst = 1'b1;

        // Column rotation: four cycles per column.
        for (int k = 1; k <= 16; k++) begin
            @(negedge clkIn);
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            chk("col_rotation", int'(col), int'(exp_col));
        end

        // Table-driven presses.
        for (int i = 0; i < 6; i++) begin
            tick(i * 3);
            press_and_release(vecs[i].r, vecs[i].c, vecs[i].hold, vecs[i].code, $sformatf("vec%0d", i));
        end

        // Bouncing key: no strobe while contacts chatter.
        strobe_t.delete();
        strobe_c.delete();
        for (int i = 0; i < 8; i++) begin
            keys[3][1] = ~keys[3][1];
            tick(3);
        end
        chk("bounce_no_strobe", strobe_c.size(), 0);
        press_and_release(3, 1, 3, 4'hF, "bounce");

        // Two keys on one column: ghost pattern is ignored, scanning continues.
        strobe_t.delete();
        strobe_c.delete();
        keys[0][3] = 1'b1;
        keys[2][3] = 1'b1;
        seen = 4'h0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clkIn);
            seen = seen | ~col;
        end
        chk("multi_no_strobe", strobe_c.size(), 0);
        chk("multi_col_rotates", int'(seen), 4'hF);
        keys[2][3] = 1'b0;
        press_and_release(0, 3, 3, 4'hA, "multi_release");

        // Reset while a key is accepted and still down.
        strobe_t.delete();
        strobe_c.delete();
        keys[2][2] = 1'b1;
        wait_accept(200, ok);
        chk("rst_pressed_accept", int'(ok), 1);
        tick(2);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_col", int'(col), 4'hE);
        chk("rst_mid_code", int'(key_code), 0);
        chk("rst_mid_valid", int'(key_valid), 0);
        chk("rst_mid_held", int'(key_held), 0);
        tick(3);
        rst = 1'b1;
        press_and_release(2, 2, 3, 4'h9, "rst_repress");

        // Randomized presses against the keypad-legend reference.
        for (int i = 0; i < 20; i++) begin
            rr = int'($urandom_range(0, 3));
            cc = int'($urandom_range(0, 3));
            tick(int'($urandom_range(0, 12)));
            press_and_release(rr, cc, int'($urandom_range(0, 10)), ref_code(rr, cc), $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
